// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data_ram between the CPU and a host port,
// CPU first, with a starvation counter that hands the host priority for one grant.
module dmem_arbiter #(
    parameter int addr_width   = 8,
    parameter int data_width   = 8,
    parameter int starve_limit = 4
) (
    input  logic                  clk,
    input  logic                  start,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [addr_width-1:0] cpu_addr,
    input  logic [data_width-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [data_width-1:0] cpu_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [addr_width-1:0] host_addr,
    input  logic [data_width-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [data_width-1:0] host_rdata,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);
    logic [3:0] starve_q, starve_d;
    logic       prio_q, prio_d;
    logic       cpu_rv_q, host_rv_q;
    always_comb begin
        cpu_gnt   = prio_q ? cpu_req & ~host_req : cpu_req;
        host_gnt  = prio_q ? host_req : host_req & ~cpu_req;
        cpu_stall = cpu_req & ~cpu_gnt;
        ram_write = (cpu_gnt & cpu_we) | (host_gnt & host_we);
        ram_read  = (cpu_gnt & ~cpu_we) | (host_gnt & ~host_we);
        ram_addr  = cpu_gnt ? cpu_addr : host_gnt ? host_addr : '0;
        ram_din   = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
        starve_d  = (host_req & ~host_gnt) ? (starve_q == 4'hf ? starve_q : starve_q + 4'd1) : 4'd0;
        // priority is judged on the count already reached, and drops once the host wins
        prio_d    = ~host_gnt & (starve_q >= 4'(starve_limit));
    end
    always_ff @(posedge clk) begin
        if (start) begin
            starve_q  <= '0;
            prio_q    <= 1'b0;
            cpu_rv_q  <= 1'b0;
            host_rv_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            prio_q    <= prio_d;
            cpu_rv_q  <= cpu_gnt & ~cpu_we;
            host_rv_q <= host_gnt & ~host_we;
        end
    end
    assign cpu_rvalid  = cpu_rv_q;
    assign host_rvalid = host_rv_q;
    assign cpu_rdata   = cpu_rv_q ? ram_dout : '0;
    assign host_rdata  = host_rv_q ? ram_dout : '0;
endmodule
